stopwatch_ctrl_fsm: RTL and testbench
=====================================

Name: stopwatch_ctrl_fsm

Overview:
Front-panel controller that sequences the four-digit stopwatch datapath from two raw push-buttons and the datapath's terminal-count flag. It debounces both buttons and tells short presses from long presses on the lap/reset button. A Moore FSM produces the datapath's run level, single-cycle clr and lap strobes, and a display select for live versus frozen lap time. It sits between the board buttons and the stopwatch counter/lap-register datapath.

Parameters:
DB_CYCLES, 1000, consecutive stable clk cycles required before a debounced level changes
LONG_CYCLES, 1500000, debounced hold length (clk cycles) that classifies a lap/reset press as long
LAP_HOLD_CYCLES, 3000000, LAPVIEW auto-return time (used only with LAP_TIMEOUT_EN)
CNT_W, 24, width of the internal debounce/hold/timeout counters; must hold the largest cycle parameter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn_ss  input  1  raw start/stop button, asynchronous, active-high
btn_lr  input  1  raw lap/reset button, asynchronous, active-high
at_limit  input  1  datapath terminal count (max when counting up, zero when counting down), synchronous to clk
run  output  1  counter enable level to the datapath
clr  output  1  one-cycle clear strobe to the datapath
lap  output  1  one-cycle lap-capture strobe to the datapath
show_lap  output  1  1 = display frozen lap registers, 0 = display live count
state  output  3  current FSM state encoding, for debug LEDs

Behaviour:
- Reset: all flops clear asynchronously. state=IDLE (3'd0), run=0, clr=0, lap=0, show_lap=0, debounced levels=0, all counters=0.
- Input conditioning: each button passes through a 2-flop synchronizer, then a debouncer. The debounced level takes the synced value once the synced value has differed from it for DB_CYCLES consecutive cycles; any agreement resets the counter to 0.
- ss_evt: one-cycle pulse on the debounced btn_ss rising edge.
- lr hold counter: counts while debounced btn_lr=1 and saturates.
  - When the count reaches LONG_CYCLES, lr_long pulses once and the rest of that press is ignored.
  - Release before LONG_CYCLES produces lr_short on the release cycle.
- State encodings: IDLE=0, RUN=1, PAUSE=2, LAPVIEW=3, DONE=4. Codes 5-7 recover to IDLE on the next clk.
- Event priority within one cycle: lr_long > at_limit > ss_evt > lr_short. Lower-priority events in the same cycle are dropped.
- Transitions; the listed strobe is asserted for exactly one cycle, registered with the state change:
  - any state, lr_long -> IDLE, with clr
  - IDLE: ss_evt -> RUN; lr_short -> IDLE, with clr
  - RUN: at_limit -> DONE; ss_evt -> PAUSE; lr_short -> LAPVIEW, with lap
  - LAPVIEW: at_limit -> DONE; ss_evt -> PAUSE; lr_short -> LAPVIEW, with lap (recapture)
  - PAUSE: ss_evt -> RUN; lr_short -> IDLE, with clr
  - DONE: lr_short -> IDLE, with clr; ss_evt ignored
- Moore outputs, registered:
  - run=1 only in RUN and LAPVIEW.
  - show_lap=1 only in LAPVIEW.
  - state mirrors the state register.
- at_limit is sampled only in RUN and LAPVIEW and ignored elsewhere.
- Latency: raw button edge to debounced edge is 2+DB_CYCLES cycles; debounced event to output change is 1 cycle.
- Reset mid-press: counters clear, and a button still held after reset must first be released; a held button yields no event.

Optional Feature:
LAP_TIMEOUT_EN
- Defined: entering LAPVIEW, including a recapture, loads a timer with LAP_HOLD_CYCLES. When the timer expires in LAPVIEW with no higher-priority event, the FSM returns to RUN (show_lap=0, run stays 1). The timer event ranks below lr_short.
- Undefined: no timer logic. LAPVIEW persists until lr_short, ss_evt, at_limit or lr_long.

Test Plan:
Bench parameters: DB_CYCLES=4, LONG_CYCLES=20, LAP_HOLD_CYCLES=10.
- Bounce: btn_ss toggled every 2 cycles for 12 cycles, then held high -> exactly one ss_evt; run rises at 2+4+1 cycles after the final stable edge; state=1.
- Lap: in RUN, btn_lr held for 8 debounced cycles -> one lap pulse on release, state=3, show_lap=1, run=1; a second short press -> second lap pulse, state stays 3.
- Long clear: in PAUSE, btn_lr held for 25 cycles -> clr pulses once at hold count 20, state=0; the later release gives no lr_short.
- Limit: in RUN, at_limit=1 and ss_evt in the same cycle -> state=4, run=0, no PAUSE; then lr_short -> clr, state=0.
- Timeout: with LAP_TIMEOUT_EN, in LAPVIEW with no input -> state=1, show_lap=0 after 10 cycles. Without LAP_TIMEOUT_EN -> still state=3 after 100 cycles.
- Async reset asserted mid-RUN with btn_ss held -> all outputs 0 immediately; after rst deasserts, no ss_evt until btn_ss is released and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl_fsm_if.sv
// Stopwatch front-panel control bundle: raw buttons and terminal count in,
// datapath control levels/strobes and debug state out.
interface stopwatch_ctrl_fsm_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       at_limit;
  logic       run;
  logic       clr;
  logic       lap;
  logic       show_lap;
  logic [2:0] state;

  modport master (
    output btn_ss, btn_lr, at_limit,
    input  run, clr, lap, show_lap, state
  );

  modport slave (
    input  btn_ss, btn_lr, at_limit,
    output run, clr, lap, show_lap, state
  );
endinterface

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch front-panel controller: synchronises and debounces the start/stop
// and lap/reset buttons, classifies lap/reset presses as short or long, and
// runs a Moore FSM that drives the counter datapath.
// Optional macro LAP_TIMEOUT_EN: LAPVIEW falls back to RUN after
// LAP_HOLD_CYCLES with no other event.
module stopwatch_ctrl_fsm #(
  parameter int DB_CYCLES       = 1000,
  parameter int LONG_CYCLES     = 1500000,
  parameter int LAP_HOLD_CYCLES = 3000000,
  parameter int CNT_W           = 24
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    LAPVIEW = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_N    = CNT_W'(LONG_CYCLES);

  // Counters must be wide enough for every cycle parameter.
  if ((longint'(DB_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(LONG_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(LAP_HOLD_CYCLES) >= (longint'(1) << CNT_W))) begin : g_cnt_w_check
    $error("CNT_W too small for the cycle parameters");
  end

  // Bit 0 = start/stop, bit 1 = lap/reset.
  logic [1:0]            raw, s1, s2, db, db_d, armed;
  logic [1:0][CNT_W-1:0] db_cnt;
  logic [1:0]            fill;
  logic [CNT_W-1:0]      hold;
  logic                  ss_evt, lr_long, lr_short, lim, lap_to;

  state_t st, st_nx;
  logic   clr_nx, lap_nx;
  logic   run_q, clr_q, lap_q, show_q;

  assign raw = {bus.btn_lr, bus.btn_ss};

  // Synchroniser fill count: s2 holds a real button sample only once this reaches 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fill <= '0;
    else if (fill != 2'd2)  fill <= fill + 2'd1;
  end

  // Two-flop sync, debounce, and release-arming per button. A button only
  // produces events after it has been seen released since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      db_d   <= '0;
      armed  <= '0;
      db_cnt <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
        if (fill == 2'd2 && !s2[i] && !db[i]) armed[i] <= 1'b1;
      end
    end
  end

  // Lap/reset hold length; saturating at LONG_CYCLES marks the press as consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 hold <= '0;
    else if (!db[1])         hold <= '0;
    else if (hold != LONG_N) hold <= hold + CNT_W'(1);
  end

  assign ss_evt   = armed[0] & db[0] & ~db_d[0];
  assign lr_long  = armed[1] & db[1] & (hold == LONG_LAST);
  assign lr_short = armed[1] & ~db[1] & db_d[1] & (hold != LONG_N);
  assign lim      = bus.at_limit & ((st == RUN) | (st == LAPVIEW));

`ifdef LAP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(LAP_HOLD_CYCLES);
  logic [CNT_W-1:0] tmr;

  // LAPVIEW timer: reloaded on every entry (including recapture), counts down in LAPVIEW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               tmr <= '0;
    else if (st_nx == LAPVIEW && (st != LAPVIEW || lap_nx)) tmr <= HOLD_N;
    else if (st == LAPVIEW && tmr != '0)                   tmr <= tmr - CNT_W'(1);
  end

  assign lap_to = (st == LAPVIEW) && (tmr == CNT_W'(1));
`else
  assign lap_to = 1'b0;
`endif

  // Next state and strobes; priority lr_long > at_limit > ss_evt > lr_short > timeout.
  always_comb begin
    st_nx  = st;
    clr_nx = 1'b0;
    lap_nx = 1'b0;
    if (lr_long) begin
      st_nx  = IDLE;
      clr_nx = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (ss_evt) st_nx = RUN;
          else if (lr_short) clr_nx = 1'b1;
        end
        RUN, LAPVIEW: begin
          if (lim)         st_nx = DONE;
          else if (ss_evt) st_nx = PAUSE;
          else if (lr_short) begin
            st_nx  = LAPVIEW;
            lap_nx = 1'b1;
          end else if (lap_to) st_nx = RUN;
        end
        PAUSE: begin
          if (ss_evt) st_nx = RUN;
          else if (lr_short) begin
            st_nx  = IDLE;
            clr_nx = 1'b1;
          end
        end
        DONE: begin
          if (lr_short) begin
            st_nx  = IDLE;
            clr_nx = 1'b1;
          end
        end
        default: st_nx = IDLE;
      endcase
    end
  end

  // State register with registered Moore outputs and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      run_q  <= 1'b0;
      clr_q  <= 1'b0;
      lap_q  <= 1'b0;
      show_q <= 1'b0;
    end else begin
      st     <= st_nx;
      run_q  <= (st_nx == RUN) || (st_nx == LAPVIEW);
      clr_q  <= clr_nx;
      lap_q  <= lap_nx;
      show_q <= (st_nx == LAPVIEW);
    end
  end

  assign bus.state    = st;
  assign bus.run      = run_q;
  assign bus.clr      = clr_q;
  assign bus.lap      = lap_q;
  assign bus.show_lap = show_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: event-level reference model compared every
// cycle, plus directed scenarios with hand-computed latencies and states.
module tb_stopwatch_ctrl_fsm;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl_fsm_if bus ();

  stopwatch_ctrl_fsm #(
    .DB_CYCLES(DB), .LONG_CYCLES(LONG), .LAP_HOLD_CYCLES(HOLD), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state (states: 0 idle, 1 run, 2 pause, 3 lapview, 4 done)
  bit [1:0] m_sy [2];
  bit       m_db [2];
  bit       m_dbp [2];
  bit       m_arm [2];
  int       m_diff [2];
  int       m_plen, m_age, m_st;
  bit       m_longed, m_clr, m_lap;

  // Reference model: button conditioning -> events -> priority-ordered transition.
  always @(posedge clk or posedge rst) begin : model
    bit raw [2];
    bit old_db [2];
    bit e_ss, e_long, e_short, e_lim, e_to, n_clr, n_lap;
    int n_st;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_sy[i] = 2'b00; m_db[i] = 0; m_dbp[i] = 0; m_arm[i] = 0; m_diff[i] = 0;
      end
      m_plen = 0; m_longed = 0; m_age = 0; m_st = 0; m_clr = 0; m_lap = 0;
    end else begin
      raw[0] = bus.btn_ss;
      raw[1] = bus.btn_lr;
      e_ss    = m_db[0] && !m_dbp[0] && m_arm[0];
      e_long  = m_db[1] && m_arm[1] && (m_plen + 1 == LONG);
      e_short = !m_db[1] && m_dbp[1] && m_arm[1] && !m_longed;
      e_lim   = bus.at_limit && (m_st == 1 || m_st == 3);
`ifdef LAP_TIMEOUT_EN
      e_to    = (m_st == 3) && (m_age + 1 == HOLD);
`else
      e_to    = 0;
`endif
      n_st = m_st; n_clr = 0; n_lap = 0;
      if (e_long) begin
        n_st = 0; n_clr = 1;
      end else if (e_lim) begin
        n_st = 4;
      end else if (e_ss && m_st != 4) begin
        n_st = (m_st == 1 || m_st == 3) ? 2 : 1;
      end else if (e_short) begin
        if (m_st == 1 || m_st == 3) begin n_st = 3; n_lap = 1; end
        else begin n_st = 0; n_clr = 1; end
      end else if (e_to) begin
        n_st = 1;
      end
      if (n_st == 3 && (m_st != 3 || n_lap)) m_age = 0;
      else if (m_st == 3) m_age++;
      m_st = n_st; m_clr = n_clr; m_lap = n_lap;

      for (int i = 0; i < 2; i++) begin
        old_db[i] = m_db[i];
        if (!raw[i] && !m_db[i]) m_arm[i] = 1;
        if (m_sy[i][1] != m_db[i]) begin
          m_diff[i]++;
          if (m_diff[i] == DB) begin m_db[i] = m_sy[i][1]; m_diff[i] = 0; end
        end else begin
          m_diff[i] = 0;
        end
        m_dbp[i] = old_db[i];
        m_sy[i]  = {m_sy[i][0], raw[i]};
      end
      if (old_db[1]) begin
        m_plen++;
        if (m_plen == LONG) m_longed = 1;
      end else begin
        m_plen = 0; m_longed = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [6:0] got, exp;
    got = {bus.state, bus.run, bus.clr, bus.lap, bus.show_lap};
    exp = {3'(m_st), (m_st == 1 || m_st == 3), m_clr, m_lap, (m_st == 3)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got st=%0d run=%b clr=%b lap=%b show=%b want st=%0d run=%b clr=%b lap=%b show=%b",
               $time, got[6:4], got[3], got[2], got[1], got[0], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which, input int len);
    if (which == 0) bus.btn_ss = 1'b1; else bus.btn_lr = 1'b1;
    idle(len);
    if (which == 0) bus.btn_ss = 1'b0; else bus.btn_lr = 1'b0;
  endtask

  // sel: 0 run high, 1 lap pulse, 2 clr pulse, 3 state left LAPVIEW. n=0 on timeout.
  task automatic wait_for(input int sel, input int maxn, output int n);
    n = 0;
    for (int k = 1; k <= maxn; k++) begin
      @(negedge clk);
      if ((sel == 0 && bus.run) || (sel == 1 && bus.lap) ||
          (sel == 2 && bus.clr) || (sel == 3 && bus.state != 3'd3)) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin : stim
    int n, clr_at, nclr;
    rst = 1'b1;
    bus.btn_ss = 1'b0; bus.btn_lr = 1'b0; bus.at_limit = 1'b0;
    idle(2);
    chk("reset_out", int'({bus.state, bus.run, bus.clr, bus.lap, bus.show_lap}), 0);
    rst = 1'b0;
    idle(5);

    // Bouncing start/stop, then a clean hold
    for (int k = 0; k < 12; k++) begin
      bus.btn_ss = ((k / 2) % 2 == 0);
      @(negedge clk);
    end
    bus.btn_ss = 1'b1;
    wait_for(0, 20, n);
    chk("bounce_latency", n, 7);
    chk("bounce_state", int'(bus.state), 1);
    idle(6);
    bus.btn_ss = 1'b0;
    idle(12);
    chk("bounce_single_evt", int'(bus.state), 1);

    // Short lap presses from RUN
    press(1, 8);
    wait_for(1, 20, n);
    chk("lap1_latency", n, 7);
    chk("lap1_state", int'(bus.state), 3);
    chk("lap1_run_show", int'({bus.run, bus.show_lap}), 3);
    idle(4);
    press(1, 8);
    wait_for(1, 20, n);
    chk("lap2_latency", n, 7);
    chk("lap2_state", int'(bus.state), 3);

`ifdef LAP_TIMEOUT_EN
    wait_for(3, 30, n);
    chk("lap_timeout_cycles", n, 10);
    chk("lap_timeout_state", int'({bus.state, bus.show_lap}), 2);
`else
    idle(100);
    chk("lapview_persists", int'({bus.state, bus.show_lap}), 7);
`endif

    press(0, 8);
    idle(10);
    chk("pause_state", int'(bus.state), 2);

    // Long hold clears from PAUSE; its release makes no short press
    bus.btn_lr = 1'b1;
    clr_at = 0; nclr = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 25) bus.btn_lr = 1'b0;
      if (bus.clr) begin
        nclr++;
        if (clr_at == 0) clr_at = k;
      end
    end
    chk("long_clr_cycle", clr_at, 26);
    chk("long_clr_count", nclr, 1);
    chk("long_clr_state", int'(bus.state), 0);

    // at_limit ignored in IDLE; at_limit beats ss_evt in RUN
    bus.at_limit = 1'b1;
    idle(5);
    bus.at_limit = 1'b0;
    chk("limit_ignored_idle", int'(bus.state), 0);
    press(0, 8);
    idle(12);
    chk("run_again", int'(bus.state), 1);
    bus.btn_ss = 1'b1;
    idle(6);
    bus.at_limit = 1'b1;
    @(negedge clk);
    bus.at_limit = 1'b0;
    chk("limit_state", int'(bus.state), 4);
    chk("limit_run", int'(bus.run), 0);
    idle(3);
    bus.btn_ss = 1'b0;
    idle(12);
    press(0, 8);
    idle(12);
    chk("done_ignores_ss", int'(bus.state), 4);
    press(1, 8);
    wait_for(2, 20, n);
    chk("done_clr_latency", n, 7);
    chk("done_clr_state", int'(bus.state), 0);

    // Async reset mid-RUN with start/stop held
    press(0, 8);
    idle(12);
    chk("pre_rst_run", int'(bus.state), 1);
    bus.btn_ss = 1'b1;
    idle(3);
    #2 rst = 1'b1;
    #1 chk("async_rst_out", int'({bus.state, bus.run, bus.clr, bus.lap, bus.show_lap}), 0);
    idle(3);
    rst = 1'b0;
    idle(20);
    chk("held_no_evt", int'(bus.state), 0);
    bus.btn_ss = 1'b0;
    idle(12);
    chk("release_no_evt", int'(bus.state), 0);
    bus.btn_ss = 1'b1;
    wait_for(0, 20, n);
    chk("rearm_latency", n, 7);
    bus.btn_ss = 1'b0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "bench timeout");
  end
endmodule
